// File: rtl/delta_h_seq.sv
// delta_h_seq
//   Sequenced hidden-layer delta: o = (sum_i prevd[i]*w[i]) * a*(1-a).
//   A single signed WIDTH x WIDTH fixed-point multiplier is reused. It
//   computes NUM products, then the sigmoid derivative, then the final
//   product. A result is produced NUM+2 edges after the start is accepted.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   i_start  start request, sampled only while idle
//   i_a      activation of this neuron (sigmoid output)
//   i_prevd  next-layer deltas, element i at [i*WIDTH +: WIDTH]
//   i_w      next-layer weights, same packing
//   o_busy   computation in flight (cleared on the edge that raises o_valid)
//   o_valid  one-cycle pulse marking a new result on o
//   o        delta result, held until the next result
module delta_h_seq #(
    parameter int NUM   = 2,
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [WIDTH-1:0]       i_a,
    input  logic [NUM*WIDTH-1:0]   i_prevd,
    input  logic [NUM*WIDTH-1:0]   i_w,
    output logic                   o_busy,
    output logic                   o_valid,
    output logic [WIDTH-1:0]       o
);

    localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_SIG  = 2'd2,
        S_MUL  = 2'd3
    } state_t;

    // Full-precision signed product, arithmetic shift right by FRAC (floor),
    // low WIDTH bits kept. Selecting bits [FRAC +: WIDTH] of the 2*WIDTH
    // product is exactly that shift followed by truncation.
    function automatic logic [WIDTH-1:0] fx_mul(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        logic signed [2*WIDTH-1:0] xe;
        logic signed [2*WIDTH-1:0] ye;
        logic signed [2*WIDTH-1:0] p;
        xe = $signed({{WIDTH{x[WIDTH-1]}}, x});
        ye = $signed({{WIDTH{y[WIDTH-1]}}, y});
        p  = xe * ye;
        return p[FRAC +: WIDTH];
    endfunction

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  sig_q, sig_d;
    logic [WIDTH-1:0]  o_q, o_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;

    // Operands captured at start acceptance; inputs may change afterwards.
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  prevd_q [NUM];
    logic [WIDTH-1:0]  w_q     [NUM];

    logic              load;
    logic [WIDTH-1:0]  one_minus_a;
    logic [WIDTH-1:0]  mul_x, mul_y, mul_r;

    assign load        = (state_q == S_IDLE) && i_start;
    assign one_minus_a = ONE - a_q;

    // The one shared multiplier; its operands are selected by state.
    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (state_q)
            S_MAC: begin
                mul_x = prevd_q[idx_q];
                mul_y = w_q[idx_q];
            end
            S_SIG: begin
                mul_x = a_q;
                mul_y = one_minus_a;
            end
            S_MUL: begin
                mul_x = acc_q;
                mul_y = sig_q;
            end
            default: begin
                mul_x = '0;
                mul_y = '0;
            end
        endcase
    end

    assign mul_r = fx_mul(mul_x, mul_y);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = S_MAC;
            S_MAC:   if (idx_q == LAST_IDX) state_d = S_SIG;
            S_SIG:   state_d = S_MUL;
            S_MUL:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        idx_d   = idx_q;
        acc_d   = acc_q;
        sig_d   = sig_q;
        o_d     = o_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    acc_d  = '0;
                    idx_d  = '0;
                    busy_d = 1'b1;
                end
            end
            S_MAC: begin
                // Two's-complement add, wraps on overflow.
                acc_d = acc_q + mul_r;
                idx_d = idx_q + IDX_W'(1);
            end
            S_SIG: begin
                sig_d = mul_r;
            end
            S_MUL: begin
                o_d     = mul_r;
                valid_d = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q   <= '0;
            acc_q   <= '0;
            sig_q   <= '0;
            o_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            sig_q   <= sig_d;
            o_q     <= o_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    // Operand capture needs no reset: it is only read after a load.
    always_ff @(posedge clk) begin
        if (load) begin
            a_q <= i_a;
            for (int i = 0; i < NUM; i++) begin
                prevd_q[i] <= i_prevd[i*WIDTH +: WIDTH];
                w_q[i]     <= i_w[i*WIDTH +: WIDTH];
            end
        end
    end

    assign o_busy  = busy_q;
    assign o_valid = valid_q;
    assign o       = o_q;

endmodule
